membrane_update: RTL and testbench

- Per-timestep neuron sweep engine, directly downstream of the amplitude RAM stage.
- On each timestep pulse it scans every neuron address and drives the amplitude stage's read enable and address. It consumes the returned amplitude, applies leak, integrates into a membrane-potential RAM and compares against threshold.
- Emits the spike strobe and address. The spike strobe is timed so it clears that neuron's amplitude entry, which the amplitude stage writes at its twice-delayed address.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/membrane_update_if.sv | 40 ++++
 rtl/potential_ram.sv | 44 ++++
 rtl/membrane_update.sv | 221 ++++++++++++++++++++++
 tb/tb_membrane_update.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the membrane_update neuron sweep engine.
// Holds the default array geometry, the address/potential typedefs and the
// sweep FSM state encoding.
// Ports: none (package).
// Optional feature macro used elsewhere: MEMBRANE_REFRACTORY_EN.
package snn_pkg;

    localparam int NEURON_NO  = 256;
    localparam int AMPL_WID   = 20;
    localparam int POT_WID    = 24;
    localparam int LEAK_SHIFT = 4;
    localparam int REFRAC_TS  = 2;
    localparam int ADDR_WID   = $clog2(NEURON_NO);

    typedef logic [$clog2(NEURON_NO)-1:0] addr_t;
    typedef logic [POT_WID-1:0]           pot_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

endpackage

// File: rtl/membrane_update_if.sv
// Bundle of the membrane_update control, amplitude-stage and spike signals.
// Ports (modport slave = the sweep engine, master = whoever drives it):
//   ts_start  : one-cycle timestep start pulse          (master -> slave)
//   threshold : firing threshold, 0 disables firing      (master -> slave)
//   ampl_in   : amplitude for rd_addr while rd_en=1      (master -> slave)
//   rd_en     : amplitude stage read/write enable        (slave -> master)
//   rd_addr   : neuron address being scanned             (slave -> master)
//   sp_out    : spike strobe                             (slave -> master)
//   sp_addr   : address of the spiking neuron            (slave -> master)
//   busy      : scan or drain in progress                (slave -> master)
//   done      : one-cycle end-of-sweep pulse             (slave -> master)
//   overrun   : sticky, ts_start seen while busy         (slave -> master)
interface membrane_update_if #(
    parameter int AMPL_WID = snn_pkg::AMPL_WID,
    parameter int POT_WID  = snn_pkg::POT_WID,
    parameter int ADDR_WID = snn_pkg::ADDR_WID
);

    logic                ts_start;
    logic [POT_WID-1:0]  threshold;
    logic [AMPL_WID-1:0] ampl_in;
    logic                rd_en;
    logic [ADDR_WID-1:0] rd_addr;
    logic                sp_out;
    logic [ADDR_WID-1:0] sp_addr;
    logic                busy;
    logic                done;
    logic                overrun;

    modport master (
        output ts_start, threshold, ampl_in,
        input  rd_en, rd_addr, sp_out, sp_addr, busy, done, overrun
    );

    modport slave (
        input  ts_start, threshold, ampl_in,
        output rd_en, rd_addr, sp_out, sp_addr, busy, done, overrun
    );

endinterface

// File: rtl/potential_ram.sv
// Simple dual-port RAM: one synchronous read port, one write port, same clock.
// Contents are zeroed at configuration time and are not touched by any reset,
// so state survives a reset of the surrounding logic.
// Ports:
//   clk     : clock
//   rd_en   : read enable; rd_data updates on the next edge
//   rd_addr : read address
//   rd_data : registered read data
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
module potential_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Power-up contents: every neuron starts at rest.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/membrane_update.sv
// Per-timestep neuron sweep engine. On ts_start it scans every neuron address,
// reads the returned amplitude, applies leak, integrates into the membrane
// potential RAM, compares against threshold and emits a spike strobe exactly
// two cycles after the neuron's rd_addr, lining up with the amplitude stage's
// twice-delayed write address so the spike clears that amplitude entry.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset (potential RAM is kept)
//   bus   : membrane_update_if.slave (see interface for signal list)
// Optional feature: define MEMBRANE_REFRACTORY_EN to add a per-neuron
// refractory counter that blocks integration and firing for REFRAC_TS scans
// after each spike.
module membrane_update #(
    parameter int NEURON_NO  = snn_pkg::NEURON_NO,
    parameter int AMPL_WID   = snn_pkg::AMPL_WID,
    parameter int POT_WID    = snn_pkg::POT_WID,
    parameter int LEAK_SHIFT = snn_pkg::LEAK_SHIFT,
    parameter int REFRAC_TS  = snn_pkg::REFRAC_TS
) (
    input  logic              clk,
    input  logic              reset,
    membrane_update_if.slave  bus
);

    import snn_pkg::*;

    localparam int               AW        = $clog2(NEURON_NO);
    localparam int               SW        = POT_WID + 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NEURON_NO - 1);
    localparam logic [POT_WID-1:0] POT_MAX = {POT_WID{1'b1}};

    if (AMPL_WID > POT_WID || REFRAC_TS < 0) begin : g_bad_params
        $error("membrane_update: AMPL_WID must not exceed POT_WID and REFRAC_TS must be >= 0");
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          drain_reg, drain_next;   // second DRAIN cycle marker
    logic          done_reg, done_next;
    logic          overrun_reg, overrun_next;
    logic          scan_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            drain_reg   <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            drain_reg   <= drain_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        drain_next   = drain_reg;
        done_next    = 1'b0;
        overrun_next = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ts_start) begin
                    state_next = SCAN;
                    addr_next  = '0;
                end
            end
            SCAN: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = DRAIN;
                    drain_next = 1'b0;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            DRAIN: begin
                // Two cycles: lets the last neuron reach stage 1 and write back.
                drain_next = 1'b1;
                if (drain_reg) begin
                    state_next = IDLE;
                    addr_next  = '0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A start during the done cycle lands in IDLE and is a legal restart.
        if (state_reg != IDLE && bus.ts_start) begin
            overrun_next = 1'b1;
        end
    end

    assign scan_en     = (state_reg == SCAN);
    assign bus.rd_en   = scan_en;
    assign bus.rd_addr = addr_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = done_reg;
    assign bus.overrun = overrun_reg;

    // ------------------------------------------------------------------
    // Stage 0: capture amplitude and address; potential RAM read in flight
    // ------------------------------------------------------------------
    logic                s0_valid_reg;
    logic [AW-1:0]       s0_addr_reg;
    logic [AMPL_WID-1:0] s0_ampl_reg;
    logic [POT_WID-1:0]  pot_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid_reg <= 1'b0;
            s0_addr_reg  <= '0;
            s0_ampl_reg  <= '0;
        end else begin
            s0_valid_reg <= scan_en;
            if (scan_en) begin
                s0_addr_reg <= addr_reg;
                s0_ampl_reg <= bus.ampl_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: leak, integrate with saturation, threshold
    // ------------------------------------------------------------------
    logic [POT_WID-1:0] leaked;
    logic [SW-1:0]      sum;
    logic [POT_WID-1:0] v_sat;
    logic               fire_raw;
    logic               fire;
    logic [POT_WID-1:0] v_wr;

    always_comb begin
        leaked   = pot_rd - (pot_rd >> LEAK_SHIFT);
        sum      = {1'b0, leaked} + SW'(s0_ampl_reg);
        v_sat    = sum[POT_WID] ? POT_MAX : sum[POT_WID-1:0];
        fire_raw = (bus.threshold != '0) && (v_sat >= bus.threshold);
    end

    potential_ram #(
        .DEPTH (NEURON_NO),
        .WIDTH (POT_WID)
    ) u_pot_ram (
        .clk     (clk),
        .rd_en   (scan_en),
        .rd_addr (addr_reg),
        .rd_data (pot_rd),
        .wr_en   (s0_valid_reg),
        .wr_addr (s0_addr_reg),
        .wr_data (v_wr)
    );

`ifdef MEMBRANE_REFRACTORY_EN
    localparam int CW = (REFRAC_TS > 0) ? $clog2(REFRAC_TS + 1) : 1;

    logic [CW-1:0] cnt_rd;
    logic [CW-1:0] cnt_wr;

    potential_ram #(
        .DEPTH (NEURON_NO),
        .WIDTH (CW)
    ) u_refrac_ram (
        .clk     (clk),
        .rd_en   (scan_en),
        .rd_addr (addr_reg),
        .rd_data (cnt_rd),
        .wr_en   (s0_valid_reg),
        .wr_addr (s0_addr_reg),
        .wr_data (cnt_wr)
    );

    // A refractory neuron stays clamped at rest and counts down one per scan.
    always_comb begin
        fire   = 1'b0;
        v_wr   = '0;
        cnt_wr = '0;
        if (cnt_rd != '0) begin
            cnt_wr = cnt_rd - 1'b1;
        end else begin
            fire   = fire_raw;
            v_wr   = fire_raw ? '0 : v_sat;
            cnt_wr = fire_raw ? CW'(REFRAC_TS) : '0;
        end
    end
`else
    always_comb begin
        fire = fire_raw;
        v_wr = fire_raw ? '0 : v_sat;
    end
`endif

    // ------------------------------------------------------------------
    // Output stage: spike two cycles after the neuron's rd_addr
    // ------------------------------------------------------------------
    logic          sp_out_reg;
    logic [AW-1:0] sp_addr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_out_reg  <= 1'b0;
            sp_addr_reg <= '0;
        end else begin
            sp_out_reg <= s0_valid_reg & fire;
            if (s0_valid_reg) begin
                sp_addr_reg <= s0_addr_reg;
            end
        end
    end

    assign bus.sp_out  = sp_out_reg;
    assign bus.sp_addr = sp_addr_reg;

endmodule

// File: tb/tb_membrane_update.sv
// Self-checking bench for membrane_update. Two instances: dut_a with default
// parameters for integration, spike timing, reset and overrun behaviour, and
// dut_b (16 neurons, LEAK_SHIFT=8) for the saturation run. Expected spikes are
// hand-computed and queued when a timestep is launched; a monitor pops and
// compares whenever sp_out is high. Honours MEMBRANE_REFRACTORY_EN.
module tb_membrane_update;

    localparam int NA = 256;
    localparam int NB = 16;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    membrane_update_if #(.AMPL_WID(20), .POT_WID(24), .ADDR_WID(8)) ifa ();
    membrane_update_if #(.AMPL_WID(20), .POT_WID(24), .ADDR_WID(4)) ifb ();

    membrane_update #(
        .NEURON_NO(NA), .AMPL_WID(20), .POT_WID(24), .LEAK_SHIFT(4), .REFRAC_TS(2)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    membrane_update #(
        .NEURON_NO(NB), .AMPL_WID(20), .POT_WID(24), .LEAK_SHIFT(8), .REFRAC_TS(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    // Amplitude stage models: combinational return for the scanned address.
    logic [19:0] ampl_a [NA];
    logic [19:0] ampl_b [NB];
    assign ifa.ampl_in = ifa.rd_en ? ampl_a[ifa.rd_addr] : 20'd0;
    assign ifb.ampl_in = ifb.rd_en ? ampl_b[ifb.rd_addr] : 20'd0;

    exp_t qa[$];
    exp_t qb[$];
    int   pend_a[$];
    int   pend_b[$];
    exp_t ea;
    exp_t eb;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (ifa.sp_out) begin
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_spike: sp_addr=%0d, expected no spike (cyc=%0d)", ifa.sp_addr, cyc);
            end else begin
                ea = qa.pop_front();
                check("a_spike_addr", 64'(ifa.sp_addr), 64'(ea.addr));
                check("a_spike_cycle", 64'(cyc), 64'(ea.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.sp_out) begin
            if (qb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected_spike: sp_addr=%0d, expected no spike (cyc=%0d)", ifb.sp_addr, cyc);
            end else begin
                eb = qb.pop_front();
                check("b_spike_addr", 64'(ifb.sp_addr), 64'(eb.addr));
                check("b_spike_cycle", 64'(cyc), 64'(eb.cyc));
            end
        end
    end

    // Launch one timestep on dut_a from a negedge and return at the negedge of
    // its done cycle. overrun_at >= 0 pulses ts_start again at that scan cycle.
    task automatic run_ts_a(input int overrun_at);
        int   t0;
        int   busy_n;
        int   seq_err;
        bit   got;
        exp_t e;
        ifa.ts_start = 1'b1;
        @(negedge clk);
        ifa.ts_start = 1'b0;
        t0 = cyc;
        check("a_first_rd_en", 64'(ifa.rd_en), 64'd1);
        check("a_first_rd_addr", 64'(ifa.rd_addr), 64'd0);
        foreach (pend_a[i]) begin
            e.addr = pend_a[i];
            e.cyc  = t0 + pend_a[i] + 2;
            qa.push_back(e);
        end
        pend_a.delete();
        busy_n  = 0;
        seq_err = 0;
        got     = 1'b0;
        for (int k = 0; k < NA + 20; k++) begin
            if (ifa.busy) busy_n++;
            if ((k < NA) != ifa.rd_en) seq_err++;
            if (k < NA && ifa.rd_addr != 8'(k)) seq_err++;
            ifa.ts_start = (k == overrun_at);
            @(negedge clk);
            if (ifa.done) begin
                got = 1'b1;
                break;
            end
        end
        ifa.ts_start = 1'b0;
        if (!got) fail_now("a_done_timeout");
        else check("a_done_cycle", 64'(cyc - t0), 64'(NA + 2));
        check("a_busy_cycles", 64'(busy_n), 64'(NA + 2));
        check("a_scan_sequence_errors", 64'(seq_err), 64'd0);
        check("a_missing_spikes", 64'(qa.size()), 64'd0);
    endtask

    task automatic run_ts_b();
        int   t0;
        bit   got;
        exp_t e;
        ifb.ts_start = 1'b1;
        @(negedge clk);
        ifb.ts_start = 1'b0;
        t0 = cyc;
        foreach (pend_b[i]) begin
            e.addr = pend_b[i];
            e.cyc  = t0 + pend_b[i] + 2;
            qb.push_back(e);
        end
        pend_b.delete();
        got = 1'b0;
        for (int k = 0; k < NB + 20; k++) begin
            @(negedge clk);
            if (ifb.done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("b_done_timeout");
        else check("b_done_cycle", 64'(cyc - t0), 64'(NB + 2));
        check("b_missing_spikes", 64'(qb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  hit;
        ifa.ts_start  = 1'b0;
        ifa.threshold = '0;
        ifb.ts_start  = 1'b0;
        ifb.threshold = '0;
        for (int i = 0; i < NA; i++) ampl_a[i] = '0;
        for (int i = 0; i < NB; i++) ampl_b[i] = '0;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(ifa.rd_en), 64'd0);
        check("rst_rd_addr", 64'(ifa.rd_addr), 64'd0);
        check("rst_sp_out", 64'(ifa.sp_out), 64'd0);
        check("rst_sp_addr", 64'(ifa.sp_addr), 64'd0);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_done", 64'(ifa.done), 64'd0);
        check("rst_overrun", 64'(ifa.overrun), 64'd0);
        check("rst_b_busy", 64'(ifb.busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Integration with leak on neuron 3 and spike timing on neuron 5.
        // ts1: v3=100, v5=1000>=1000 fires (written 0).
        ifa.threshold = 24'd1000;
        ampl_a[3] = 20'd100;
        ampl_a[5] = 20'd1000;
        pend_a.push_back(5);
        run_ts_a(-1);
        // ts2: v3=100-6+100=194; v5=0 with ampl 0, no spike.
        ampl_a[5] = 20'd0;
        run_ts_a(-1);
        // ts3: v3=194-12=182 < 183, no spike.
        ampl_a[3] = 20'd0;
        ifa.threshold = 24'd183;
        run_ts_a(-1);
        // ts4: v3=182-11=171 >= 171, spike.
        ifa.threshold = 24'd171;
        pend_a.push_back(3);
        run_ts_a(-1);

        // Neuron 2 driven at threshold every timestep.
        ifa.threshold = 24'd500;
        ampl_a[2] = 20'd500;
        for (int ts = 1; ts <= 4; ts++) begin
`ifdef MEMBRANE_REFRACTORY_EN
            if (ts == 1 || ts == 4) pend_a.push_back(2);
`else
            pend_a.push_back(2);
`endif
            run_ts_a(-1);
        end
        ampl_a[2] = 20'd0;
        // Every start above coincided with the previous done pulse.
        check("no_overrun_on_done_restart", 64'(ifa.overrun), 64'd0);

        // Reset mid-scan at rd_addr=100 while neuron 98's spike is on sp_out.
        ifa.threshold = 24'd1000;
        ampl_a[98]  = 20'd1000;
        ampl_a[50]  = 20'd100;
        ampl_a[150] = 20'd100;
        ifa.ts_start = 1'b1;
        @(negedge clk);
        ifa.ts_start = 1'b0;
        t0 = cyc;
        begin
            exp_t e;
            e.addr = 98;
            e.cyc  = t0 + 100;
            qa.push_back(e);
        end
        hit = 1'b0;
        for (int k = 0; k < NA + 10; k++) begin
            if (ifa.rd_en && ifa.rd_addr == 8'd100) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) fail_now("rst_mid_scan_addr100_timeout");
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_rd_en", 64'(ifa.rd_en), 64'd0);
        check("rst_mid_busy", 64'(ifa.busy), 64'd0);
        check("rst_mid_sp_out", 64'(ifa.sp_out), 64'd0);
        check("rst_mid_rd_addr", 64'(ifa.rd_addr), 64'd0);
        ampl_a[98]  = 20'd0;
        ampl_a[50]  = 20'd0;
        ampl_a[150] = 20'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_idle_after_release", 64'(ifa.busy), 64'd0);
        check("rst_mid_missing_spike98", 64'(qa.size()), 64'd0);
        // v50 kept at 100 -> 100-6=94 fires; v150 never written -> stays 0.
        ifa.threshold = 24'd94;
        pend_a.push_back(50);
        run_ts_a(-1);

        // Overrun: extra ts_start at scan cycle 10 is ignored but flagged.
        check("overrun_clear_before", 64'(ifa.overrun), 64'd0);
        ifa.threshold = 24'd1000;
        run_ts_a(10);
        check("overrun_set", 64'(ifa.overrun), 64'd1);
        repeat (3) @(negedge clk);
        check("overrun_sticky", 64'(ifa.overrun), 64'd1);
        check("overrun_no_restart", 64'(ifa.busy), 64'd0);

        // Saturation on dut_b neuron 0: threshold 0 never fires.
        ifb.threshold = 24'd0;
        ampl_b[0] = 20'hFFFFF;
        for (int ts = 0; ts < 300; ts++) begin
            run_ts_b();
        end
        // Saturated v0: 16777215-65535+1048575 clamps to 16777215 >= max.
        ifb.threshold = 24'hFFFFFF;
        pend_b.push_back(0);
        run_ts_b();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
